// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the channel scan multiplexer.
package chan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } scan_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_scan_mux_if.sv
// Valid/ready output stream carrying one sample and its channel index.
interface chan_scan_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_data, input out_ch, input out_valid, output out_ready);

endinterface

// File: rtl/next_en_idx.sv
// Finds the next enabled channel index starting at (incl=1) or after (incl=0)
// the start index, wrapping modulo NUM_CH.
module next_en_idx #(
    parameter int  NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [SEL_W-1:0]  start,
    input  logic              incl,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    logic [31:0]      cand;
    logic [SEL_W-1:0] cand_idx;

    // The exclusive search reaches start itself last, so a lone enabled
    // channel reselects itself.
    always_comb begin
        idx      = '0;
        found    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand     = (32'(start) + 32'(k) + (incl ? 32'd0 : 32'd1)) % NUM_CH;
            cand_idx = SEL_W'(cand);
            if (!found && ch_en[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// N-channel registered multiplexer with manual select and an autonomous
// dwell-timed scan over the enabled channels, feeding a valid/ready stream.
//
//   state   | meaning
//   IDLE    | no scan activity; pick first enabled channel at/after cur_ch
//   CAPTURE | waiting for a free output register to sample cur_ch
//   HOLD    | dwell countdown after a capture, independent of backpressure
module chan_scan_mux
    import chan_mux_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  DATA_W  = 8,
    parameter int  DWELL_W = 8,
    localparam int SEL_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic [NUM_CH*DATA_W-1:0] din,
    chan_scan_mux_if.master          bus
);

    scan_state_t       state, state_d;
    logic [SEL_W-1:0]  cur_ch, cur_ch_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_d;
    logic              mode_q;

    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_q;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic              load_ok;
    logic              man_ok;
    logic              scan_cap;
    logic              cap;
    logic              clr;
    logic [SEL_W-1:0]  cap_ch;

    logic [SEL_W-1:0]  incl_idx, excl_idx;
    logic              incl_found, excl_found;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_data[i] = din[i*DATA_W +: DATA_W];
    end

    next_en_idx #(.NUM_CH(NUM_CH)) u_first (
        .ch_en (ch_en),
        .start (cur_ch),
        .incl  (1'b1),
        .idx   (incl_idx),
        .found (incl_found)
    );

    next_en_idx #(.NUM_CH(NUM_CH)) u_next (
        .ch_en (ch_en),
        .start (cur_ch),
        .incl  (1'b0),
        .idx   (excl_idx),
        .found (excl_found)
    );

    assign load_ok = !out_valid_q || bus.out_ready;
    assign man_ok  = (32'(sel) < NUM_CH) && ch_en[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_ch    <= '0;
            dwell_cnt <= '0;
            mode_q    <= MODE_MANUAL;
        end else begin
            state     <= state_d;
            cur_ch    <= cur_ch_d;
            dwell_cnt <= dwell_cnt_d;
            mode_q    <= mode;
        end
    end

    always_comb begin
        state_d     = state;
        cur_ch_d    = cur_ch;
        dwell_cnt_d = dwell_cnt;
        scan_cap    = 1'b0;
        if (mode != mode_q || mode == MODE_MANUAL) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (incl_found) begin
                        cur_ch_d = incl_idx;
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!ch_en[cur_ch]) begin
                        state_d = IDLE;
                    end else if (load_ok) begin
                        scan_cap    = 1'b1;
                        dwell_cnt_d = dwell;
                        if (dwell == '0) begin
                            if (excl_found) cur_ch_d = excl_idx;
                            else            state_d  = IDLE;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    dwell_cnt_d = dwell_cnt - DWELL_W'(1);
                    if (dwell_cnt <= DWELL_W'(1)) begin
                        dwell_cnt_d = '0;
                        if (excl_found) begin
                            cur_ch_d = excl_idx;
                            state_d  = CAPTURE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A held sample is only replaced or cleared once the register is free.
    always_comb begin
        cap    = 1'b0;
        clr    = 1'b0;
        cap_ch = cur_ch;
        if (mode == MODE_MANUAL) begin
            if (load_ok) begin
                if (man_ok) begin
                    cap    = 1'b1;
                    cap_ch = sel;
                end else begin
                    clr = 1'b1;
                end
            end
        end else if (scan_cap) begin
            cap = 1'b1;
        end else if (load_ok) begin
            clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (cap) begin
            out_data_q  <= ch_data[cap_ch];
            out_ch_q    <= cap_ch;
            out_valid_q <= 1'b1;
        end else if (clr) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: reset, manual select, scan cadence,
// backpressure and scan corner cases.
module tb_chan_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [3:0]  ch_en = '0;
    logic [7:0]  dwell = '0;
    logic [31:0] din = '0;

    int n_chk = 0;
    int n_fail = 0;

    chan_scan_mux_if #(.NUM_CH(4), .DATA_W(8)) bus ();

    chan_scan_mux #(.NUM_CH(4), .DATA_W(8), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .ch_en (ch_en),
        .dwell (dwell),
        .din   (din),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [7:0] v);
        din[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < limit && !ok) begin
            step();
            cycles++;
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.out_data); end
        n_chk++; if (bus.out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %0d want 0", bus.out_ch); end
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_manual();
        logic [1:0] sels [3] = '{2'd2, 2'd1, 2'd3};
        logic [7:0] exps [3] = '{8'hA5, 8'h21, 8'h3C};
        mode = 1'b0;
        ch_en = 4'hF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = sels[i];
            step();
            n_chk++; if (bus.out_data !== exps[i]) begin n_fail++; $display("FAIL manual_data[%0d] got %h want %h", i, bus.out_data, exps[i]); end
            n_chk++; if (bus.out_ch !== sels[i]) begin n_fail++; $display("FAIL manual_ch[%0d] got %0d want %0d", i, bus.out_ch, sels[i]); end
            n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL manual_valid[%0d] got %b want 1", i, bus.out_valid); end
        end
    endtask

    task automatic test_manual_disabled();
        sel = 2'd1;
        step();
        bus.out_ready = 1'b0;
        ch_en = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h21 || bus.out_ch !== 2'd1) begin
                n_fail++; $display("FAIL man_dis_hold[%0d] got v=%b d=%h c=%0d want v=1 d=21 c=1", i, bus.out_valid, bus.out_data, bus.out_ch);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL man_dis_drop[%0d] got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp_ch [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
        logic [7:0] exp_d  [4] = '{8'h10, 8'h21, 8'h3C, 8'h10};
        int cyc;
        bit ok;
        do_reset();
        mode = 1'b1;
        ch_en = 4'b1011;
        dwell = 8'd2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(12, cyc, ok);
            n_chk++;
            if (!ok) begin
                n_fail++; $display("FAIL scan_timeout[%0d] got no valid want valid within 12", i);
            end else begin
                if (bus.out_ch !== exp_ch[i] || bus.out_data !== exp_d[i]) begin
                    n_fail++; $display("FAIL scan_seq[%0d] got c=%0d d=%h want c=%0d d=%h", i, bus.out_ch, bus.out_data, exp_ch[i], exp_d[i]);
                end
                if (i > 0) begin
                    n_chk++; if (cyc != 3) begin n_fail++; $display("FAIL scan_period[%0d] got %0d want 3", i, cyc); end
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || bus.out_ch !== 2'd0) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d want v=1 d=10 c=0", i, bus.out_valid, bus.out_data, bus.out_ch);
            end
        end
        bus.out_ready = 1'b1;
        step();
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h21 || bus.out_ch !== 2'd1) begin
            n_fail++; $display("FAIL bp_release got v=%b d=%h c=%0d want v=1 d=21 c=1", bus.out_valid, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_scan_edges();
        int cyc;
        bit ok;
        bus.out_ready = 1'b0;
        ch_en = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1) begin
            n_fail++; $display("FAIL noen_pending got v=%b c=%0d want v=1 c=1", bus.out_valid, bus.out_ch);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL noen_idle[%0d] got %b want 0", i, bus.out_valid); end
        end
        ch_en = 4'b0100;
        dwell = 8'd0;
        wait_valid(10, cyc, ok);
        n_chk++; if (!ok || bus.out_ch !== 2'd2 || bus.out_data !== 8'hA5) begin
            n_fail++; $display("FAIL dwell0_first got ok=%b c=%0d d=%h want ok=1 c=2 d=a5", ok, bus.out_ch, bus.out_data);
        end
        for (int i = 0; i < 5; i++) begin
            set_ch(2, 8'h50 + 8'(i));
            step();
            n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd2 || bus.out_data !== 8'h50 + 8'(i)) begin
                n_fail++; $display("FAIL dwell0_each[%0d] got v=%b c=%0d d=%h want v=1 c=2 d=%h", i, bus.out_valid, bus.out_ch, bus.out_data, 8'h50 + 8'(i));
            end
        end
        set_ch(2, 8'hA5);
    endtask

    task automatic test_reset_mid_hold();
        int cyc;
        bit ok;
        do_reset();
        mode = 1'b1;
        ch_en = 4'b1010;
        dwell = 8'd5;
        bus.out_ready = 1'b0;
        wait_valid(12, cyc, ok);
        n_chk++; if (!ok || bus.out_ch !== 2'd1 || bus.out_data !== 8'h21) begin
            n_fail++; $display("FAIL rst_pre got ok=%b c=%0d d=%h want ok=1 c=1 d=21", ok, bus.out_ch, bus.out_data);
        end
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data got %h want 00", bus.out_data); end
        n_chk++; if (bus.out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_mid_ch got %0d want 0", bus.out_ch); end
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", bus.out_valid); end
        step();
        step();
        ch_en = 4'b1011;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        wait_valid(12, cyc, ok);
        n_chk++; if (!ok || bus.out_ch !== 2'd0 || bus.out_data !== 8'h10) begin
            n_fail++; $display("FAIL rst_restart got ok=%b c=%0d d=%h want ok=1 c=0 d=10", ok, bus.out_ch, bus.out_data);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        set_ch(0, 8'h10);
        set_ch(1, 8'h21);
        set_ch(2, 8'hA5);
        set_ch(3, 8'h3C);
        test_reset();
        test_manual();
        test_manual_disabled();
        test_scan();
        test_back_pressure();
        test_scan_edges();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
